scan_test_controller: RTL
=========================

Name: scan_test_controller

Overview:
- Tester-side driver for the scan chain: loads a stimulus pattern into the chain, optionally pulses one capture cycle, then unloads the chain and compares the response against an expected vector under a mask.
- Drives scan_en/scan_in into the chain and reads the chain's serial scan_out, making it the opposite end of the chain's scan interface.
- Sits between a test-sequencing block or CPU register file and the scan_chain instance.

Parameters:
- CHAIN_LEN, 4, number of flops in the attached chain (legal range ≥2).
- CNT_W, $clog2(CHAIN_LEN+1), width of the shift counter; derived, do not override.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- start  in  1  request a test; honoured only in IDLE.
- capture_en  in  1  1 = insert capture cycle; 0 = pure flush/integrity test. Latched at start.
- pattern_in  in  CHAIN_LEN  stimulus; MSB shifted first. Latched at start.
- expect_in  in  CHAIN_LEN  expected response. Latched at start.
- mask_in  in  CHAIN_LEN  1 = compare this bit. Latched at start.
- scan_out  in  1  serial output of the chain's last flop, registered in the chain.
- scan_en  out  1  to chain; 1 = shift, 0 = functional/capture.
- scan_in  out  1  serial data to the chain.
- busy  out  1  high from the cycle after start is accepted until DONE ends.
- done  out  1  single-cycle pulse when results are valid.
- pass  out  1  (fail_map == 0); held until the next accepted start.
- fail_map  out  CHAIN_LEN  (captured ^ expect) & mask; held.
- captured  out  CHAIN_LEN  unloaded response, MSB = first bit unloaded; held.

Behaviour:
- All outputs are registered.
- Reset values: scan_en=0, scan_in=0, busy=0, done=0, pass=0, fail_map=0, captured=0, state=IDLE, counter=0.
- IDLE:
  - start=1 latches pattern/expect/mask/capture_en, loads counter=CHAIN_LEN-1 and goes to SHIFT.
  - With start=0, scan_en=0 and scan_in=0.
- SHIFT, CHAIN_LEN cycles:
  - scan_en=1.
  - In shift cycle k (k=0..N-1), scan_in = pattern[N-1-k].
  - Counter decrements each cycle; at 0 go to CAPTURE if capture_en else UNLOAD.
- CAPTURE, 1 cycle:
  - scan_en=0, scan_in=0; the chain performs its functional capture on the closing edge.
  - Then go to UNLOAD with counter=CHAIN_LEN-1.
- UNLOAD, CHAIN_LEN cycles:
  - scan_en=1, scan_in=0 so the chain is flushed to zero.
  - On the closing edge of unload cycle k, scan_out is sampled into captured[N-1-k], shifting MSB-first.
  - At counter 0 go to DONE.
- DONE, 1 cycle:
  - done=1.
  - captured, fail_map and pass update on the edge entering DONE and stay stable until the next accepted start.
  - Then go to IDLE.
- Latency from the edge that samples start:
  - done is high in cycle 2N+2 with capture, 2N+1 without.
  - N=4: cycle 10 with capture, 9 without.
- Loopback identity: with a pure shift chain and capture_en=0, captured == pattern.
- Boundary cases:
  - start while busy, including the DONE cycle, is ignored with no queuing.
  - Input changes after start is accepted have no effect.
  - mask=0 gives pass=1 regardless of data.
  - rst_n=0 in any state: at the next edge all outputs return to reset values, done is not asserted, and the previous results are cleared.
  - start and rst_n=0 in the same cycle: reset wins.

Decomposition:
- Package scan_pkg holds:
  - state enum {IDLE, SHIFT, CAPTURE, UNLOAD, DONE};
  - the default CHAIN_LEN constant, shared with scan_chain.
- One sub-module, scan_shift_counter:
  - load and decrement, with a terminal-count flag;
  - parameterised on CNT_W;
  - reused by both SHIFT and UNLOAD.

Test Plan:
- Loopback, N=4: pattern 4'b1011, expect 4'b1011, mask 4'b1111, capture_en=0, bench chain is a plain 4-bit shift register.
  -> scan_in = 1,0,1,1 during SHIFT with scan_en=1; captured=1011; pass=1; fail_map=0000; done in cycle 9 only.
- Capture path: bench chain loads ~q on capture; pattern 1011, expect 0100, capture_en=1.
  -> one scan_en=0 cycle between the shifts; captured=0100; pass=1; done in cycle 10.
- Mismatch and mask: same as the capture-path test but expect 0000.
  -> with mask 1111: fail_map=0100, pass=0.
  -> rerun with mask 1011: fail_map=0000, pass=1.
- Start while busy: pulse start in SHIFT cycle 2 and again in the DONE cycle with a different pattern.
  -> both ignored; single done pulse; results reflect the first pattern.
- Reset mid-SHIFT: rst_n=0 during shift cycle 2.
  -> next edge gives scan_en=0, busy=0, captured=0, pass=0; no done pulse; a following start behaves as in the loopback test.
- Results hold: after done, leave start=0 for 20 cycles while toggling the inputs.
  -> captured, pass and fail_map unchanged; scan_en stays 0.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared definitions for the scan test controller and the scan chain it drives.
package scan_pkg;

   // Default chain length, shared with the scan_chain instance
   localparam int DEF_CHAIN_LEN = 4;

   // Controller sequencing states
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SHIFT   = 3'd1,
      CAPTURE = 3'd2,
      UNLOAD  = 3'd3,
      DONE    = 3'd4
   } state_t;

endpackage

// File: rtl/scan_shift_counter.sv
// Loadable down-counter with terminal-count flag; paces both the load and
// unload shift phases of the scan controller.
module scan_shift_counter #(
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             tc
);

   logic [CNT_W-1:0] count;

   // Load takes priority over decrement; reset parks the counter at zero
   always_ff @(posedge clk) begin
      if (!rst_n)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (dec)
         count <= count - 1'b1;
   end

   assign tc = (count == '0);

endmodule

// File: rtl/scan_test_controller.sv
// Tester-side scan driver: shifts a pattern into the chain, optionally pulses
// one capture cycle, unloads the response and compares it under a mask.
module scan_test_controller
   import scan_pkg::*;
#(
   parameter int CHAIN_LEN = DEF_CHAIN_LEN,
   parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 capture_en,
   input  logic [CHAIN_LEN-1:0] pattern_in,
   input  logic [CHAIN_LEN-1:0] expect_in,
   input  logic [CHAIN_LEN-1:0] mask_in,
   input  logic                 scan_out,
   output logic                 scan_en,
   output logic                 scan_in,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [CHAIN_LEN-1:0] fail_map,
   output logic [CHAIN_LEN-1:0] captured
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

   state_t               state;
   logic [CHAIN_LEN-1:0] pat_sr;     // remaining stimulus bits, next one at MSB
   logic [CHAIN_LEN-1:0] exp_q;
   logic [CHAIN_LEN-1:0] mask_q;
   logic                 cap_q;
   logic [CHAIN_LEN-1:0] unl_sr;     // response being assembled during UNLOAD
   logic [CHAIN_LEN-1:0] unl_next;
   logic [CHAIN_LEN-1:0] fail_next;
   logic                 cnt_load;
   logic                 cnt_dec;
   logic                 cnt_tc;

   // Final unload edge folds the last scan_out bit straight into the results
   assign unl_next  = {unl_sr[CHAIN_LEN-2:0], scan_out};
   assign fail_next = (unl_next ^ exp_q) & mask_q;

   // Counter control: reload for each shift phase, count down within it
   always_comb begin
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      case (state)
         IDLE:    cnt_load = start;
         SHIFT:   if (cnt_tc) cnt_load = ~cap_q; else cnt_dec = 1'b1;
         CAPTURE: cnt_load = 1'b1;
         UNLOAD:  cnt_dec  = ~cnt_tc;
         default: ;
      endcase
   end

   scan_shift_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cnt_load),
      .load_val (LAST),
      .dec      (cnt_dec),
      .tc       (cnt_tc)
   );

   // Sequencer: outputs are registered one cycle ahead of the phase they serve
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         scan_en  <= 1'b0;
         scan_in  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         pass     <= 1'b0;
         fail_map <= '0;
         captured <= '0;
         pat_sr   <= '0;
         exp_q    <= '0;
         mask_q   <= '0;
         cap_q    <= 1'b0;
         unl_sr   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               scan_en <= 1'b0;
               scan_in <= 1'b0;
               if (start) begin
                  state   <= SHIFT;
                  busy    <= 1'b1;
                  scan_en <= 1'b1;
                  scan_in <= pattern_in[CHAIN_LEN-1];
                  pat_sr  <= pattern_in << 1;
                  exp_q   <= expect_in;
                  mask_q  <= mask_in;
                  cap_q   <= capture_en;
               end
            end
            SHIFT: begin
               if (cnt_tc) begin
                  scan_in <= 1'b0;
                  if (cap_q) begin
                     state   <= CAPTURE;
                     scan_en <= 1'b0;
                  end else begin
                     state   <= UNLOAD;
                  end
               end else begin
                  scan_in <= pat_sr[CHAIN_LEN-1];
                  pat_sr  <= pat_sr << 1;
               end
            end
            CAPTURE: begin
               state   <= UNLOAD;
               scan_en <= 1'b1;
               scan_in <= 1'b0;
            end
            UNLOAD: begin
               unl_sr <= unl_next;
               if (cnt_tc) begin
                  state    <= DONE;
                  scan_en  <= 1'b0;
                  done     <= 1'b1;
                  captured <= unl_next;
                  fail_map <= fail_next;
                  pass     <= (fail_next == '0);
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
